game_seq_ctrl: RTL

Round sequencer for the music game. It debounces the start and pause buttons, runs a countdown before each song, and holds the note/score datapath in reset between rounds. During play it gates the slow tick into the datapath, supports pause/resume and abort, and holds the final score after the song ends. Sits between the board buttons and the game top level; drives the datapath reset and speed.

---
 rtl/game_seq_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/game_seq_ctrl.sv
// Round sequencer for the music game: button debounce, countdown, play/pause/done control.
// Optional BEST_SCORE_EN macro adds best_score / new_best tracking across rounds.
module game_seq_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_TICKS  = 4,
  parameter int END_HOLD   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        tick,
  input  logic        song_end,
  input  logic [2:0]  speed_in,
  input  logic [11:0] score,
  output logic        dp_rst,
  output logic        run_en,
  output logic [2:0]  speed,
  output logic [1:0]  countdown,
  output logic [2:0]  state,
  output logic [11:0] final_score
`ifdef BEST_SCORE_EN
  ,
  output logic [11:0] best_score,
  output logic        new_best
`endif
);

  localparam int TMAX = (CNT_TICKS > END_HOLD) ? CNT_TICKS : END_HOLD;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int DW   = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Lane 0 = start, lane 1 = pause
  logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]         deb_q, deb_d, press_q, press_d;
  logic [1:0][DW-1:0] dcnt_q, dcnt_d;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [1:0]    cd_q, cd_d;
  logic [2:0]    speed_q, speed_d;
  logic [11:0]   fscore_q, fscore_d;
  logic          start_p, pause_p;

  assign start_p = press_q[0];
  assign pause_p = press_q[1];

  always_comb begin
    sync1_d = {pause_btn, start_btn};
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      deb_d[i]   = deb_q[i];
      press_d[i] = 1'b0;
      dcnt_d[i]  = '0;
      // Any return to the accepted level zeroes the count, so a bounce restarts it
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_d[i]   = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    cd_d     = cd_q;
    speed_d  = speed_q;
    fscore_d = fscore_q;
    case (state_q)
      IDLE: begin
        if (start_p) begin
          state_d = COUNT;
          speed_d = speed_in;
          cd_d    = 2'd3;
          tcnt_d  = '0;
        end
      end
      COUNT: begin
        if (start_p) begin
          state_d = IDLE;
          cd_d    = 2'd0;
        end else if (tick) begin
          if (tcnt_inc == TW'(CNT_TICKS)) begin
            tcnt_d = '0;
            cd_d   = cd_q - 2'd1;
            if (cd_q == 2'd1) state_d = PLAY;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
      end
      PLAY: begin
        if (song_end) begin
          state_d  = DONE;
          fscore_d = score;
          tcnt_d   = '0;
        end else if (pause_p) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (start_p)      state_d = IDLE;
        else if (pause_p) state_d = PLAY;
      end
      DONE: begin
        if (start_p) begin
          state_d = COUNT;
          speed_d = speed_in;
          cd_d    = 2'd3;
          tcnt_d  = '0;
        end else if (tick) begin
          if (tcnt_inc == TW'(END_HOLD)) state_d = IDLE;
          else                           tcnt_d  = tcnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cd_d    = 2'd0;
        tcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      press_q  <= '0;
      dcnt_q   <= '0;
      state_q  <= IDLE;
      tcnt_q   <= '0;
      cd_q     <= '0;
      speed_q  <= '0;
      fscore_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      press_q  <= press_d;
      dcnt_q   <= dcnt_d;
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      cd_q     <= cd_d;
      speed_q  <= speed_d;
      fscore_q <= fscore_d;
    end
  end

  assign dp_rst      = (state_q == PLAY) || (state_q == PAUSE) || (state_q == DONE);
  assign run_en      = (state_q == PLAY);
  assign speed       = speed_q;
  assign countdown   = cd_q;
  assign state       = state_q;
  assign final_score = fscore_q;

`ifdef BEST_SCORE_EN
  logic [11:0] best_q, best_d;
  logic        nb_q, nb_d;

  always_comb begin
    best_d = best_q;
    nb_d   = nb_q;
    if (state_q == PLAY && song_end && score > best_q) begin
      best_d = score;
      nb_d   = 1'b1;
    end
    if (state_q == DONE && state_d != DONE) nb_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      best_q <= '0;
      nb_q   <= 1'b0;
    end else begin
      best_q <= best_d;
      nb_q   <= nb_d;
    end
  end

  assign best_score = best_q;
  assign new_best   = nb_q;
`endif

endmodule
